// File: rtl/sparc_ifu_swctl_pkg.sv
// Shared definitions for the IFU thread-switch controller: thread state
// encodings, default sizing and the quantum counter width helper.
package sparc_ifu_swctl_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RDY  = 2'd1,
        ST_RUN  = 2'd2,
        ST_WAIT = 2'd3
    } thr_st_e;

    localparam int NTHR_DEF  = 4;
    localparam int QUANT_DEF = 16;

    function automatic int quant_cw(input int quant);
        return $clog2(quant);
    endfunction

endpackage

// File: rtl/sparc_ifu_rrpick.sv
// Round-robin one-hot picker: first eligible requester after ptr, with wrap.
// Purely combinational so the return-path arbiters can share it.
module sparc_ifu_rrpick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    input  logic [N-1:0]         excl_i,
    output logic [N-1:0]         gnt_o,
    output logic                 any_o
);

    localparam int PW = $clog2(N);

    logic [N-1:0]  elig;
    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        any_o = 1'b0;
        idx   = '0;
        elig  = req_i & ~excl_i;
        // ptr itself is visited last, so the previous winner has lowest priority
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr_i) + k) % N);
            if (!any_o && elig[idx]) begin
                gnt_o[idx] = 1'b1;
                any_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparc_ifu_swctl.sv
// IFU thread-switch controller: parks threads on switch points, rotates on
// quantum expiry, and round-robins issue among ready threads.
module sparc_ifu_swctl
    import sparc_ifu_swctl_defs::*;
#(
    parameter int NTHR  = NTHR_DEF,
    parameter int QUANT = QUANT_DEF
) (
    input  logic            rclk,
    input  logic            arst_l,
    input  logic [NTHR-1:0] thr_en,
    input  logic            inst_vld_s,
    input  logic            stall_s,
    input  logic            swpl_s,
    input  logic [NTHR-1:0] thr_rdy_in,
    output logic [NTHR-1:0] thr_s,
    output logic            switch_s,
    output logic [NTHR-1:0] thr_wait,
    output logic            all_idle
);

    localparam int PW = $clog2(NTHR);
    localparam int CW = quant_cw(QUANT);

    thr_st_e         st_q [NTHR];
    thr_st_e         st_d [NTHR];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [NTHR-1:0] run_vec, rdy_vec, act_vec, gnt;
    logic [PW-1:0]   gnt_idx;
    logic            issue, run_any, run_on, cnt_exp, pick_any;
    logic            rel, sel, take;

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            run_vec[i]  = (st_q[i] == ST_RUN);
            // a RDY thread being disabled this cycle must not be picked
            rdy_vec[i]  = (st_q[i] == ST_RDY) && thr_en[i];
            act_vec[i]  = (st_q[i] == ST_RUN) || (st_q[i] == ST_RDY);
            thr_wait[i] = (st_q[i] == ST_WAIT);
        end
    end

    sparc_ifu_rrpick #(.N(NTHR)) u_pick (
        .req_i  (rdy_vec),
        .ptr_i  (ptr_q),
        .excl_i (run_vec),
        .gnt_o  (gnt),
        .any_o  (pick_any)
    );

    always_comb begin
        issue   = inst_vld_s & ~stall_s;
        run_any = |run_vec;
        run_on  = |(run_vec & thr_en);
        cnt_exp = (cnt_q == CW'(QUANT - 1));
        rel     = run_any & (~run_on | (issue & swpl_s) | (issue & cnt_exp & pick_any));
        sel     = rel | ~run_any;
        take    = sel & pick_any;
        gnt_idx = '0;
        for (int i = 0; i < NTHR; i++) begin
            if (gnt[i]) gnt_idx = PW'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            st_d[i] = st_q[i];
            if (!thr_en[i]) begin
                st_d[i] = ST_IDLE;
            end else begin
                case (st_q[i])
                    ST_IDLE: st_d[i] = ST_RDY;
                    ST_RDY:  if (take && gnt[i]) st_d[i] = ST_RUN;
                    // an enabled RUN thread only releases on a switch point or expiry
                    ST_RUN:  if (rel) st_d[i] = (issue && swpl_s && !thr_rdy_in[i]) ? ST_WAIT : ST_RDY;
                    ST_WAIT: if (thr_rdy_in[i]) st_d[i] = ST_RDY;
                    default: st_d[i] = ST_IDLE;
                endcase
            end
        end
        ptr_d = take ? gnt_idx : ptr_q;
        cnt_d = cnt_q;
        if (rel || take)
            cnt_d = '0;
        else if (issue && run_any)
            cnt_d = cnt_exp ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            for (int i = 0; i < NTHR; i++) st_q[i] <= ST_IDLE;
            ptr_q <= PW'(NTHR - 1);
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NTHR; i++) st_q[i] <= st_d[i];
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    assign thr_s    = run_vec;
    assign switch_s = rel | (~run_any & pick_any);
    assign all_idle = ~|act_vec;

endmodule

// File: tb/tb_sparc_ifu_swctl.sv
// Directed bench for sparc_ifu_swctl: each cycle's stimulus pushes the
// hand-derived outputs for that cycle; a negedge monitor pops and compares.
module tb_sparc_ifu_swctl;

    logic       rclk = 1'b0;
    logic       arst_l = 1'b0;
    logic [3:0] thr_en = '0;
    logic       inst_vld_s = 1'b0;
    logic       stall_s = 1'b0;
    logic       swpl_s = 1'b0;
    logic [3:0] thr_rdy_in = '0;
    logic [3:0] thr_s, thr_wait;
    logic       switch_s, all_idle;

    typedef struct {
        int         id;
        logic [3:0] thr;
        logic [3:0] wt;
        logic       idle;
        logic       sw;
    } exp_t;

    exp_t q[$];
    int   vec_n = 0;
    int   miss_n = 0;
    int   id_n = 0;

    sparc_ifu_swctl #(.NTHR(4), .QUANT(16)) dut (
        .rclk       (rclk),
        .arst_l     (arst_l),
        .thr_en     (thr_en),
        .inst_vld_s (inst_vld_s),
        .stall_s    (stall_s),
        .swpl_s     (swpl_s),
        .thr_rdy_in (thr_rdy_in),
        .thr_s      (thr_s),
        .switch_s   (switch_s),
        .thr_wait   (thr_wait),
        .all_idle   (all_idle)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
        if (act !== exp) begin
            miss_n++;
            $display("FAIL %s vec %0d: got %b want %b", nm, id, act, exp);
        end
    endtask

    always @(negedge rclk) begin : mon
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            vec_n++;
            chk("thr_s",    e.id, thr_s, e.thr);
            chk("thr_wait", e.id, thr_wait, e.wt);
            chk("all_idle", e.id, {3'b0, all_idle}, {3'b0, e.idle});
            chk("switch_s", e.id, {3'b0, switch_s}, {3'b0, e.sw});
        end
    end

    task automatic cyc(input logic rst, input logic [3:0] en, input logic vld, input logic stl,
                       input logic swp, input logic [3:0] rdy, input logic [3:0] e_thr,
                       input logic [3:0] e_wt, input logic e_idle, input logic e_sw);
        exp_t e;
        @(posedge rclk);
        #1;
        arst_l = rst; thr_en = en; inst_vld_s = vld; stall_s = stl;
        swpl_s = swp; thr_rdy_in = rdy;
        e.id = id_n; e.thr = e_thr; e.wt = e_wt; e.idle = e_idle; e.sw = e_sw;
        id_n++;
        q.push_back(e);
    endtask

    // reset, release with en, then the cycle where enabled threads sit in RDY
    task automatic boot(input logic [3:0] en);
        cyc(1'b0, 4'b0000, 0, 0, 0, 4'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, en,      0, 0, 0, 4'b0, 4'b0000, 4'b0000, 1'b1, 1'b0);
        cyc(1'b1, en,      0, 0, 0, 4'b0, 4'b0000, 4'b0000, en == 4'b0, en != 4'b0);
    endtask

    localparam logic [3:0] F = 4'b1111;

    initial begin
        // quantum rotation with continuous non-switch issue
        boot(F);
        for (int k = 0; k < 16; k++) cyc(1, F, 1, 0, 0, 4'b0, 4'b0001, 4'b0, 0, k == 15);
        for (int k = 0; k < 16; k++) cyc(1, F, 1, 0, 0, 4'b0, 4'b0010, 4'b0, 0, k == 15);
        cyc(1, F, 0, 0, 0, 4'b0, 4'b0100, 4'b0, 0, 0);

        // switch point, late wake, simultaneous wake, disable under stall
        boot(F);
        cyc(1, F, 1, 0, 1, 4'b0000, 4'b0001, 4'b0000, 0, 1);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0010, 4'b0001, 0, 0);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0010, 4'b0001, 0, 0);
        cyc(1, F, 0, 0, 0, 4'b0001, 4'b0010, 4'b0001, 0, 0);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0010, 4'b0000, 0, 0);
        cyc(1, F, 1, 0, 1, 4'b0010, 4'b0010, 4'b0000, 0, 1);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0100, 4'b0000, 0, 0);
        cyc(1, 4'b1011, 1, 1, 0, 4'b0, 4'b0100, 4'b0, 0, 1);
        cyc(1, 4'b1011, 1, 1, 0, 4'b0, 4'b1000, 4'b0, 0, 0);
        for (int k = 0; k < 16; k++) cyc(1, 4'b1011, 1, 0, 0, 4'b0, 4'b1000, 4'b0, 0, k == 15);
        cyc(1, 4'b1011, 0, 0, 0, 4'b0, 4'b0001, 4'b0, 0, 0);
        // stalled cycles must not advance the quantum
        for (int k = 0; k < 20; k++) cyc(1, 4'b1011, 1, (k % 5) == 2, 0, 4'b0, 4'b0001, 4'b0, 0, k == 19);
        cyc(1, 4'b1011, 0, 0, 0, 4'b0, 4'b0010, 4'b0, 0, 0);

        // single thread: park, wake, rerun, and expiry with nobody else ready
        boot(4'b0100);
        cyc(1, 4'b0100, 1, 0, 1, 4'b0000, 4'b0100, 4'b0000, 0, 1);
        cyc(1, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0100, 1, 0);
        cyc(1, 4'b0100, 0, 0, 0, 4'b0100, 4'b0000, 4'b0100, 1, 0);
        cyc(1, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        for (int k = 0; k < 20; k++) cyc(1, 4'b0100, 1, 0, 0, 4'b0, 4'b0100, 4'b0, 0, 0);

        // async reset with two threads parked and wakes pending
        boot(F);
        cyc(1, F, 1, 0, 1, 4'b0000, 4'b0001, 4'b0000, 0, 1);
        cyc(1, F, 1, 0, 1, 4'b0000, 4'b0010, 4'b0001, 0, 1);
        cyc(1, F, 1, 0, 0, 4'b0000, 4'b0100, 4'b0011, 0, 0);
        cyc(1, F, 1, 0, 0, 4'b0000, 4'b0100, 4'b0011, 0, 0);
        cyc(0, F, 1, 0, 0, 4'b0011, 4'b0000, 4'b0000, 1, 0);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 1);
        cyc(1, F, 0, 0, 0, 4'b0000, 4'b0001, 4'b0000, 0, 0);

        @(posedge rclk);
        @(negedge rclk);
        #1;
        if (q.size() != 0) begin
            miss_n++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
